// File: rtl/mux_pipe_n_if.sv
// Signal bundle for mux_pipe_n: flattened input channels, select, pipeline
// controls and the registered result.
interface mux_pipe_n_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    valid_in;
    logic                    hold;
    logic                    flush;
    logic [WIDTH-1:0]        out;
    logic                    valid_out;
    logic                    sel_err;

    modport master (
        output in_bus, sel, valid_in, hold, flush,
        input  out, valid_out, sel_err
    );

    modport slave (
        input  in_bus, sel, valid_in, hold, flush,
        output out, valid_out, sel_err
    );
endinterface

// File: rtl/mux_pipe_n.sv
// N-way datapath selector with an optional register pipeline (0..4 stages).
// Each stage carries data, valid and an out-of-range-select flag.
module mux_pipe_n #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 4,
    parameter int               SEL_W       = 2,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    mux_pipe_n_if.slave  bus
);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("mux_pipe_n: NUM_IN must be in 2..16");
    end
    if ((1 << SEL_W) < NUM_IN) begin : g_bad_sel_w
        $error("mux_pipe_n: SEL_W too narrow to address NUM_IN channels");
    end
    if (STAGES < 0 || STAGES > 4) begin : g_bad_stages
        $error("mux_pipe_n: STAGES must be in 0..4");
    end

    logic [WIDTH-1:0] mux_d;
    logic             err_d;

    // Unmatched selects fall through to DEFAULT_VAL with the error flag set.
    always_comb begin
        mux_d = DEFAULT_VAL;
        err_d = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(bus.sel) == i) begin
                mux_d = bus.in_bus[i*WIDTH +: WIDTH];
                err_d = 1'b0;
            end
        end
    end

    if (STAGES == 0) begin : g_comb
        logic unused_ctrl;
        assign unused_ctrl   = &{1'b0, clk, rst, bus.hold, bus.flush};
        assign bus.out       = mux_d;
        assign bus.valid_out = bus.valid_in;
        assign bus.sel_err   = err_d & bus.valid_in;
    end else begin : g_pipe
        logic [WIDTH-1:0]  data_q [STAGES];
        logic [STAGES-1:0] valid_q;
        logic [STAGES-1:0] err_q;

        // Flush only clears the qualifiers; data is don't-care while invalid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < STAGES; k++) begin
                    data_q[k] <= '0;
                end
                valid_q <= '0;
                err_q   <= '0;
            end else if (bus.flush) begin
                valid_q <= '0;
                err_q   <= '0;
            end else if (!bus.hold) begin
                data_q[0]  <= mux_d;
                valid_q[0] <= bus.valid_in;
                err_q[0]   <= err_d & bus.valid_in;
                for (int k = 1; k < STAGES; k++) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                    err_q[k]   <= err_q[k-1];
                end
            end
        end

        assign bus.out       = data_q[STAGES-1];
        assign bus.valid_out = valid_q[STAGES-1];
        assign bus.sel_err   = err_q[STAGES-1];
    end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: two-stage pipes (4 and 3 channels) and a
// combinational instance, checked against hand-computed values.
module tb_mux_pipe_n;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mux_pipe_n_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) a_if ();
    mux_pipe_n_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) b_if ();
    mux_pipe_n_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) c_if ();

    mux_pipe_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .STAGES(2),
                 .DEFAULT_VAL(32'h0000_0000))
        u_a (.clk(clk), .rst(rst), .bus(a_if));

    mux_pipe_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .STAGES(2),
                 .DEFAULT_VAL(32'hDEAD_BEEF))
        u_b (.clk(clk), .rst(rst), .bus(b_if));

    mux_pipe_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .STAGES(0),
                 .DEFAULT_VAL(32'h0000_0000))
        u_c (.clk(clk), .rst(rst), .bus(c_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        a_if.in_bus = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        b_if.in_bus = {32'h33333333, 32'h22222222, 32'h11111111};
        c_if.in_bus = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        a_if.sel = 2'd0; a_if.valid_in = 1'b0; a_if.hold = 1'b0; a_if.flush = 1'b0;
        b_if.sel = 2'd0; b_if.valid_in = 1'b0; b_if.hold = 1'b0; b_if.flush = 1'b0;
        c_if.sel = 2'd0; c_if.valid_in = 1'b0; c_if.hold = 1'b0; c_if.flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out",   a_if.out, 32'h0);
        chk("rst_valid", 32'(a_if.valid_out), 32'h0);
        chk("rst_err",   32'(a_if.sel_err), 32'h0);
        rst = 1'b0;

        // Basic select and two-edge latency
        a_if.sel = 2'd2; a_if.valid_in = 1'b1;
        step();
        chk("lat_e1_valid", 32'(a_if.valid_out), 32'h0);
        a_if.sel = 2'd0;
        step();
        chk("sel2_out",   a_if.out, 32'h33333333);
        chk("sel2_valid", 32'(a_if.valid_out), 32'h1);
        a_if.sel = 2'd3;
        step();
        chk("sel0_out", a_if.out, 32'h11111111);
        a_if.sel = 2'd1; a_if.valid_in = 1'b0;
        step();
        chk("sel3_out", a_if.out, 32'h44444444);
        chk("sel3_err", 32'(a_if.sel_err), 32'h0);
        step();
        chk("bubble_valid", 32'(a_if.valid_out), 32'h0);

        // Hold: A=11 in stage 2, B=22 in stage 1
        a_if.sel = 2'd0; a_if.valid_in = 1'b1;
        step();
        a_if.sel = 2'd1;
        step();
        chk("pre_hold_out", a_if.out, 32'h11111111);
        a_if.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_out",   a_if.out, 32'h11111111);
            chk("hold_valid", 32'(a_if.valid_out), 32'h1);
        end
        a_if.hold = 1'b0; a_if.sel = 2'd3;
        step();
        chk("post_hold_out", a_if.out, 32'h22222222);

        // Flush beats hold with a full pipe
        a_if.flush = 1'b1; a_if.hold = 1'b1; a_if.sel = 2'd2;
        step();
        chk("flush_valid", 32'(a_if.valid_out), 32'h0);
        chk("flush_err",   32'(a_if.sel_err), 32'h0);
        a_if.flush = 1'b0; a_if.hold = 1'b0;
        step();
        chk("post_flush_e1_valid", 32'(a_if.valid_out), 32'h0);
        a_if.valid_in = 1'b0;
        step();
        chk("post_flush_out",   a_if.out, 32'h33333333);
        chk("post_flush_valid", 32'(a_if.valid_out), 32'h1);

        // Asynchronous reset between edges with the pipe full
        a_if.sel = 2'd1; a_if.valid_in = 1'b1;
        step();
        step();
        chk("pre_rst_out", a_if.out, 32'h22222222);
        #2 rst = 1'b1;
        #1;
        chk("arst_out",   a_if.out, 32'h0);
        chk("arst_valid", 32'(a_if.valid_out), 32'h0);
        chk("arst_err",   32'(a_if.sel_err), 32'h0);
        #1 rst = 1'b0;
        a_if.valid_in = 1'b0;
        @(negedge clk);

        // Out-of-range select with three channels
        b_if.sel = 2'd3; b_if.valid_in = 1'b1;
        step();
        b_if.sel = 2'd1;
        step();
        chk("oor_out",   b_if.out, 32'hDEADBEEF);
        chk("oor_err",   32'(b_if.sel_err), 32'h1);
        chk("oor_valid", 32'(b_if.valid_out), 32'h1);
        b_if.sel = 2'd3; b_if.valid_in = 1'b0;
        step();
        chk("inr_out", b_if.out, 32'h22222222);
        chk("inr_err", 32'(b_if.sel_err), 32'h0);
        step();
        chk("oor_invalid_err", 32'(b_if.sel_err), 32'h0);

        // Combinational instance ignores hold/flush
        c_if.hold = 1'b1; c_if.flush = 1'b1; c_if.sel = 2'd0; c_if.valid_in = 1'b1;
        #1;
        chk("comb_sel0_out", c_if.out, 32'h11111111);
        c_if.sel = 2'd1; c_if.valid_in = 1'b0;
        #1;
        chk("comb_sel1_out",   c_if.out, 32'h22222222);
        chk("comb_sel1_valid", 32'(c_if.valid_out), 32'h0);
        c_if.sel = 2'd3; c_if.valid_in = 1'b1;
        #1;
        chk("comb_sel3_out",   c_if.out, 32'h44444444);
        chk("comb_sel3_valid", 32'(c_if.valid_out), 32'h1);
        chk("comb_sel3_err",   32'(c_if.sel_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
